ysyx_22040088_ifu: RTL and testbench

Instruction fetch unit: owns the architectural PC, issues instruction-memory read requests, and presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. It is the producer that feeds the decoder's `pc`/`inst` inputs. It also accepts a PC redirect from execute (jumps and taken branches), which flushes any fetch in flight.

---
 rtl/ysyx_22040088_pkg.sv | 16 +
 rtl/ysyx_22040088_reg.sv | 22 ++
 rtl/ysyx_22040088_ifu.sv | 155 +++++++++++++++
 tb/tb_ysyx_22040088_ifu.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040088_pkg.sv
// Shared types and constants for the ysyx_22040088 fetch unit.
package ysyx_22040088_pkg;

  // Fetch FSM states; StHalt is only reachable when misaligned redirects trap.
  typedef enum logic [1:0] {
    StReq  = 2'd0,
    StWait = 2'd1,
    StHold = 2'd2,
    StHalt = 2'd3
  } ifu_state_e;

  localparam int unsigned INST_BYTES = 4;

  localparam logic [63:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

endpackage

// File: rtl/ysyx_22040088_reg.sv
// Generic register with synchronous active-high reset and write enable.
module ysyx_22040088_reg #(
  parameter int unsigned       Width    = 64,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wen_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  // Load reset value, otherwise capture d_i when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= ResetVal;
    end else if (wen_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/ysyx_22040088_ifu.sv
// Instruction fetch unit: owns the PC, issues single outstanding imem reads and
// presents fetched instructions to decode over valid/ready. Redirects from execute
// flush any fetch in flight.
// Optional: define YSYX_22040088_IFU_MISALIGN_CHECK_EN to trap misaligned redirects
// into a terminal halt state with fetch_fault raised.
module ysyx_22040088_ifu
  import ysyx_22040088_pkg::*;
#(
  parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        imem_rsp_ready,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_inst
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  ifu_state_e  state_q, state_d;
  logic        drop_q, drop_d;
  logic        pc_wen;
  logic [63:0] pc_d, pc_q;
  logic        inst_wen;
  logic [31:0] inst_q;
  logic        req_hs;
  logic [63:0] redirect_tgt;

  // Low bits are cleared on load so the PC is always word aligned.
  assign redirect_tgt = redirect_pc & ~64'h3;
  assign req_hs       = (state_q == StReq) && imem_req_ready;

`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  logic fault_q, fault_d;
  logic misalign;
  assign misalign    = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign fetch_fault = fault_q;
`endif

  ysyx_22040088_reg #(
    .Width   (64),
    .ResetVal(RESET_PC)
  ) u_pc_reg (
    .clk_i(clk),
    .rst_i(rst),
    .wen_i(pc_wen),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  ysyx_22040088_reg #(
    .Width   (32),
    .ResetVal(32'h0)
  ) u_inst_reg (
    .clk_i(clk),
    .rst_i(rst),
    .wen_i(inst_wen),
    .d_i  (imem_rsp_data),
    .q_o  (inst_q)
  );

  // State, drop flag and fault flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StReq;
      drop_q  <= 1'b0;
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
      fault_q <= fault_d;
`endif
    end
  end

  // Next-state, PC update and instruction capture; redirect always wins.
  always_comb begin
    state_d  = state_q;
    drop_d   = drop_q;
    pc_wen   = 1'b0;
    pc_d     = redirect_tgt;
    inst_wen = 1'b0;
    unique case (state_q)
      StReq: begin
        if (req_hs) state_d = StWait;
        if (redirect_valid) begin
          pc_wen = 1'b1;
          // The request just issued fetches the stale PC; discard its response.
          if (req_hs) drop_d = 1'b1;
        end
      end
      StWait: begin
        if (redirect_valid) begin
          pc_wen = 1'b1;
          drop_d = 1'b1;
        end
        if (imem_rsp_valid) begin
          drop_d = 1'b0;
          if (drop_q || redirect_valid) begin
            state_d = StReq;
          end else begin
            inst_wen = 1'b1;
            state_d  = StHold;
          end
        end
      end
      StHold: begin
        if (redirect_valid) begin
          pc_wen  = 1'b1;
          state_d = StReq;
        end else if (out_ready) begin
          pc_wen  = 1'b1;
          pc_d    = pc_q + 64'(INST_BYTES);
          state_d = StReq;
        end
      end
      StHalt: begin
      end
      default: state_d = StReq;
    endcase
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    fault_d = fault_q;
    if (misalign && (state_q != StHalt)) begin
      state_d  = StHalt;
      fault_d  = 1'b1;
      pc_wen   = 1'b0;
      inst_wen = 1'b0;
      drop_d   = 1'b0;
    end
`endif
  end

  // All outputs come from registers only.
  assign imem_req_valid = (state_q == StReq);
  assign imem_req_addr  = pc_q;
  assign imem_rsp_ready = (state_q == StWait);
  assign out_valid      = (state_q == StHold);
  assign out_pc         = pc_q;
  assign out_inst       = inst_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu.sv
// Self-checking bench for ysyx_22040088_ifu: transaction-level model of the fetch
// contract plus a behavioural instruction memory with random latency.
module tb_ysyx_22040088_ifu;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_ready;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        out_valid, out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
  logic        fetch_fault;
`endif

  always #5 clk = ~clk;

  ysyx_22040088_ifu #(
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_ready(imem_rsp_ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_pc        (out_pc),
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    .out_inst      (out_inst),
    .fetch_fault   (fetch_fault)
`else
    .out_inst      (out_inst)
`endif
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model of the fetch contract: PC, one outstanding request, whether its
  // response is stale, and the instruction currently offered to decode.
  logic [63:0] m_pc = RESET_PC;
  logic        m_out = 1'b0, m_stale = 1'b0, m_have = 1'b0, m_halt = 1'b0;
  logic [31:0] m_inst = 32'h0;

  // Memory: one pending response with a countdown; accepted-request log.
  logic        mem_pend = 1'b0, mem_real = 1'b0;
  logic [63:0] mem_addr = 64'h0;
  int          mem_cnt = 0;
  int          lat_lo = 0, lat_hi = 0;
  bit          junk_en = 1'b0;
  logic [63:0] acc_q[$];
  int          acc_cyc[$];

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] w;
    w = a[33:2];
    return w * 32'h9E37_79B1 + 32'h13;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    logic        in_rst, rv, ord, rq, rs, mis, exp_req;
    logic [63:0] rpc, tgt;
    logic [31:0] rd;
    @(negedge clk);
    in_rst = rst; rv = redirect_valid; rpc = redirect_pc; ord = out_ready;
    rq = imem_req_ready; rs = imem_rsp_valid; rd = imem_rsp_data;
    tgt = rpc & ~64'h3;
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    mis = rv && (rpc[1:0] != 2'b00);
`else
    mis = 1'b0;
`endif
    // Memory side of the upcoming edge.
    if (mem_real) mem_pend = 1'b0;
    if (imem_req_valid && rq && !in_rst) begin
      mem_pend = 1'b1;
      mem_addr = imem_req_addr;
      mem_cnt  = $urandom_range(lat_hi, lat_lo);
      acc_q.push_back(imem_req_addr);
      acc_cyc.push_back(cyc);
    end
    // Model side of the upcoming edge.
    if (in_rst) begin
      m_pc = RESET_PC; m_out = 0; m_stale = 0; m_have = 0; m_halt = 0; m_inst = 0;
    end else if (m_halt) begin
    end else if (mis) begin
      m_halt = 1; m_out = 0; m_stale = 0; m_have = 0;
    end else if (m_have) begin
      if (rv) begin
        m_pc = tgt; m_have = 0;
      end else if (ord) begin
        m_pc = m_pc + 64'd4; m_have = 0;
      end
    end else if (m_out) begin
      if (rv) m_pc = tgt;
      if (rs) begin
        if (!(m_stale || rv)) begin
          m_have = 1; m_inst = rd;
        end
        m_out = 0; m_stale = 0;
      end else if (rv) begin
        m_stale = 1;
      end
    end else begin
      if (rv) m_pc = tgt;
      if (rq) begin
        m_out = 1; m_stale = rv;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    // Compare DUT outputs with the model.
    exp_req = !m_out && !m_have && !m_halt;
    chk("req_valid", imem_req_valid, exp_req);
    chk("rsp_ready", imem_rsp_ready, m_out);
    chk("out_valid", out_valid, m_have);
    if (!m_halt) chk("pc", out_pc, m_pc);
    if (exp_req) chk("req_addr", imem_req_addr, m_pc);
    if (m_have) begin
      chk("out_inst", out_inst, m_inst);
      chk("inst_vs_mem", out_inst, mem_word(out_pc));
    end
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    chk("fetch_fault", fetch_fault, m_halt);
`endif
    // Drive memory response for the next cycle.
    mem_real = 1'b0;
    if (mem_pend && mem_cnt == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mem_addr);
      mem_real       = 1'b1;
    end else begin
      if (mem_pend) mem_cnt--;
      imem_rsp_valid = !mem_pend && junk_en && ($urandom_range(7, 0) == 0);
      imem_rsp_data  = $urandom;
    end
  endtask

  // what: 0 = out_valid, 1 = imem_rsp_ready, 2 = imem_req_valid
  task automatic wait_until(input int what, input string name);
    int n = 0;
    while (!((what == 0 && out_valid) || (what == 1 && imem_rsp_ready) ||
             (what == 2 && imem_req_valid)) && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL wait_%s: condition not reached, got 0 want 1", name);
    end
  endtask

  task automatic next_accept(output logic [63:0] a, input string name);
    int n0 = acc_q.size();
    int n = 0;
    while (acc_q.size() == n0 && n < 50) begin
      tick();
      n++;
    end
    if (acc_q.size() == n0) begin
      checks++;
      errors++;
      $display("FAIL accept_%s: no request accepted, got 0 want 1", name);
      a = 64'hx;
    end else begin
      a = acc_q[n0];
    end
  endtask

  initial begin
    logic [63:0] a, p;
    logic [31:0] ins;
    int          n;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_req_addr", imem_req_addr, 64'h8000_0000);
    chk("rst_out_valid", out_valid, 1'b0);

    // Zero-wait memory, decode always ready.
    acc_q.delete(); acc_cyc.delete();
    imem_req_ready = 1'b1; out_ready = 1'b1;
    repeat (9) tick();
    chk("zw_count_ge3", acc_q.size() >= 3, 1'b1);
    chk("zw_addr0", acc_q[0], 64'h8000_0000);
    chk("zw_addr1", acc_q[1], 64'h8000_0004);
    chk("zw_addr2", acc_q[2], 64'h8000_0008);
    chk("zw_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 64'd3);
    chk("zw_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 64'd3);

    // Decode stalls for 5 cycles in HOLD.
    out_ready = 1'b0;
    wait_until(0, "hold");
    p = out_pc; ins = out_inst; n = acc_q.size();
    repeat (5) tick();
    chk("stall_pc", out_pc, p);
    chk("stall_inst", out_inst, ins);
    chk("stall_no_req", acc_q.size(), n);
    chk("stall_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    next_accept(a, "after_stall");
    chk("stall_next", a, p + 64'd4);

    // Redirect while waiting; the response arrives two cycles later.
    lat_lo = 2; lat_hi = 2;
    wait_until(1, "wait");
    redirect_valid = 1'b1; redirect_pc = 64'h8000_1000;
    tick();
    redirect_valid = 1'b0;
    lat_lo = 0; lat_hi = 0;
    next_accept(a, "wait_redir");
    chk("wait_redir_addr", a, 64'h8000_1000);

    // Redirect in HOLD with out_ready also high.
    wait_until(0, "hold2");
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0100;
    tick();
    redirect_valid = 1'b0;
    next_accept(a, "hold_redir");
    chk("hold_redir_addr", a, 64'h8000_0100);

    // Misaligned redirect.
    imem_req_ready = 1'b0;
    wait_until(2, "req");
    redirect_valid = 1'b1; redirect_pc = 64'h8000_0102;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
    chk("mis_fault", fetch_fault, 1'b1);
    n = acc_q.size();
    repeat (10) tick();
    chk("mis_no_req", acc_q.size(), n);
    chk("mis_out_valid", out_valid, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mis_fault_clr", fetch_fault, 1'b0);
`else
    next_accept(a, "mis");
    chk("mis_addr", a, 64'h8000_0100);
`endif

    // Reset while waiting; the late response must be ignored.
    lat_lo = 3; lat_hi = 3;
    wait_until(1, "wait_rst");
    rst = 1'b1;
    tick();
    rst = 1'b0; imem_req_ready = 1'b0;
    repeat (4) tick();
    lat_lo = 0; lat_hi = 0;
    imem_req_ready = 1'b1;
    next_accept(a, "rst_wait");
    chk("rst_wait_addr", a, RESET_PC);

    // Randomized traffic.
    lat_lo = 0; lat_hi = 3; junk_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(3, 0) != 0);
      out_ready      = $urandom_range(1, 0) == 1;
      rst            = ($urandom_range(199, 0) == 0);
      redirect_valid = ($urandom_range(11, 0) == 0);
      if ($urandom_range(15, 0) == 0) redirect_pc = 64'hFFFF_FFFF_FFFF_FFF4;
      else redirect_pc = 64'h8000_0000 + 64'($urandom_range(4095, 0));
`ifdef YSYX_22040088_IFU_MISALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
      tick();
    end
    rst = 1'b0; redirect_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
